// File: rtl/aska_pkg.sv
// Shared constants, register addresses and FSM encoding for the ASKA SPI register front-end.
package aska_pkg;

  localparam int M          = 32;
  localparam int FRAME_BITS = 8 + M;

  localparam logic [7:0] ADDR_CONF0 = 8'h00;
  localparam logic [7:0] ADDR_CONF1 = 8'h01;
  localparam logic [7:0] ADDR_ELE1  = 8'h02;
  localparam logic [7:0] ADDR_ELE2  = 8'h03;

  typedef enum logic [1:0] {
    WAIT_IDLE = 2'd0,
    IDLE      = 2'd1,
    SHIFT     = 2'd2,
    DONE      = 2'd3
  } state_e;

endpackage

// File: rtl/aska_sync.sv
// Two-flop synchronizer for one asynchronous input; output lags the pin by two clk edges.
module aska_sync (
  input  logic clk,
  input  logic reset_l,
  input  logic d,
  output logic q
);

  logic s1_q, s2_q;

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= d;
      s2_q <= s1_q;
    end
  end

  assign q = s2_q;

endmodule

// File: rtl/aska_spi_slave.sv
// Oversampled SPI Mode-0 slave: 40-bit frames (8-bit address, 32-bit data) write conf0/conf1/ele1/ele2.
// Optional readback of the addressed register on SPI_MISO when SPI_READBACK_EN is defined.
module aska_spi_slave
  import aska_pkg::*;
(
  input  logic         clk,
  input  logic         reset_l,
  input  logic         SPI_CS,
  input  logic         SPI_Clk,
  input  logic         SPI_MOSI,
  output logic         SPI_MISO,
  output logic [M-1:0] conf0,
  output logic [M-1:0] conf1,
  output logic [M-1:0] ele1,
  output logic [M-1:0] ele2,
  output logic         wr_strobe,
  output logic [1:0]   wr_addr,
  output logic         frame_err
);

  logic cs_s, sclk_s, mosi_s;
  logic sclk_d1_q;
  logic sclk_rise;

  aska_sync u_sync_cs   (.clk(clk), .reset_l(reset_l), .d(SPI_CS),   .q(cs_s));
  aska_sync u_sync_sclk (.clk(clk), .reset_l(reset_l), .d(SPI_Clk),  .q(sclk_s));
  aska_sync u_sync_mosi (.clk(clk), .reset_l(reset_l), .d(SPI_MOSI), .q(mosi_s));

  state_e                state_q, state_d;
  logic [5:0]            bit_cnt_q, bit_cnt_d;
  logic [FRAME_BITS-2:0] shift_q, shift_d;
  logic                  overrun_q, overrun_d;
  logic [M-1:0]          conf0_q, conf0_d, conf1_q, conf1_d;
  logic [M-1:0]          ele1_q, ele1_d, ele2_q, ele2_d;
  logic                  wr_strobe_q, wr_strobe_d;
  logic [1:0]            wr_addr_q, wr_addr_d;
  logic                  frame_err_q, frame_err_d;
  logic [FRAME_BITS-1:0] frame_nxt;

  assign sclk_rise = sclk_s & ~sclk_d1_q;
  // The shift register plus the bit arriving this cycle: the full frame on the 40th rise.
  assign frame_nxt = {shift_q, mosi_s};

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    overrun_d   = overrun_q;
    conf0_d     = conf0_q;
    conf1_d     = conf1_q;
    ele1_d      = ele1_q;
    ele2_d      = ele2_q;
    wr_strobe_d = 1'b0;
    wr_addr_d   = wr_addr_q;
    frame_err_d = 1'b0;
    case (state_q)
      WAIT_IDLE: if (cs_s) state_d = IDLE;
      IDLE: begin
        if (!cs_s) begin
          state_d   = SHIFT;
          bit_cnt_d = '0;
          overrun_d = 1'b0;
        end
      end
      SHIFT: begin
        if (cs_s) begin
          state_d     = IDLE;
          frame_err_d = (bit_cnt_q != 6'd0);
        end else if (sclk_rise) begin
          shift_d   = frame_nxt[FRAME_BITS-2:0];
          bit_cnt_d = bit_cnt_q + 6'd1;
          if (bit_cnt_q == 6'(FRAME_BITS - 1)) begin
            state_d = DONE;
            case (frame_nxt[FRAME_BITS-1 -: 8])
              ADDR_CONF0: conf0_d = frame_nxt[M-1:0];
              ADDR_CONF1: conf1_d = frame_nxt[M-1:0];
              ADDR_ELE1:  ele1_d  = frame_nxt[M-1:0];
              ADDR_ELE2:  ele2_d  = frame_nxt[M-1:0];
              default:    frame_err_d = 1'b1;
            endcase
            if (frame_nxt[FRAME_BITS-1 -: 6] == 6'd0) begin
              wr_strobe_d = 1'b1;
              wr_addr_d   = frame_nxt[M+1:M];
            end
          end
        end
      end
      DONE: begin
        if (cs_s) begin
          state_d     = IDLE;
          frame_err_d = overrun_q;
        end else if (sclk_rise) begin
          overrun_d = 1'b1;
        end
      end
      default: state_d = WAIT_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      sclk_d1_q   <= 1'b0;
      state_q     <= WAIT_IDLE;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      overrun_q   <= 1'b0;
      conf0_q     <= '0;
      conf1_q     <= '0;
      ele1_q      <= '0;
      ele2_q      <= '0;
      wr_strobe_q <= 1'b0;
      wr_addr_q   <= '0;
      frame_err_q <= 1'b0;
    end else begin
      sclk_d1_q   <= sclk_s;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      overrun_q   <= overrun_d;
      conf0_q     <= conf0_d;
      conf1_q     <= conf1_d;
      ele1_q      <= ele1_d;
      ele2_q      <= ele2_d;
      wr_strobe_q <= wr_strobe_d;
      wr_addr_q   <= wr_addr_d;
      frame_err_q <= frame_err_d;
    end
  end

`ifdef SPI_READBACK_EN
  logic [M-1:0] tx_q, tx_d;
  logic         sclk_fall;

  assign sclk_fall = ~sclk_s & sclk_d1_q;

  // Load after the last address bit; hold TX[31] across the following fall so it is valid at rise 9.
  always_comb begin
    tx_d = tx_q;
    if (state_q == SHIFT && !cs_s) begin
      if (sclk_rise && bit_cnt_q == 6'd7) begin
        case (frame_nxt[7:0])
          ADDR_CONF0: tx_d = conf0_q;
          ADDR_CONF1: tx_d = conf1_q;
          ADDR_ELE1:  tx_d = ele1_q;
          ADDR_ELE2:  tx_d = ele2_q;
          default:    tx_d = '0;
        endcase
      end else if (sclk_fall && bit_cnt_q > 6'd8) begin
        tx_d = {tx_q[M-2:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) tx_q <= '0;
    else          tx_q <= tx_d;
  end

  assign SPI_MISO = (state_q == SHIFT && !cs_s && bit_cnt_q >= 6'd8) ? tx_q[M-1] : 1'b0;
`else
  assign SPI_MISO = 1'b0;
`endif

  assign conf0     = conf0_q;
  assign conf1     = conf1_q;
  assign ele1      = ele1_q;
  assign ele2      = ele2_q;
  assign wr_strobe = wr_strobe_q;
  assign wr_addr   = wr_addr_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_aska_spi_slave.sv
// Directed bench for aska_spi_slave: frames driven bit by bit, pulses counted on the falling clk edge.
module tb_aska_spi_slave;

  logic        clk = 1'b0;
  logic        reset_l = 1'b0;
  logic        SPI_CS = 1'b1;
  logic        SPI_Clk = 1'b0;
  logic        SPI_MOSI = 1'b0;
  logic        SPI_MISO;
  logic [31:0] conf0, conf1, ele1, ele2;
  logic        wr_strobe;
  logic [1:0]  wr_addr;
  logic        frame_err;

  aska_spi_slave dut (
    .clk(clk), .reset_l(reset_l), .SPI_CS(SPI_CS), .SPI_Clk(SPI_Clk),
    .SPI_MOSI(SPI_MOSI), .SPI_MISO(SPI_MISO), .conf0(conf0), .conf1(conf1),
    .ele1(ele1), .ele2(ele2), .wr_strobe(wr_strobe), .wr_addr(wr_addr),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int strobe_cnt = 0;
  int err_cnt = 0;
  int strobe_cyc = 0;
  int last_rise = 0;
  logic [1:0]  last_waddr = 2'd0;
  logic [31:0] rx = '0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (wr_strobe) begin
      strobe_cnt++;
      last_waddr = wr_addr;
      strobe_cyc = cyc;
    end
    if (frame_err) err_cnt++;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Drive n bits of f starting at bit position 'first' (0 = MSB); bits past 40 are 0.
  task automatic spi_bits(input logic [39:0] f, input int first, input int n);
    for (int i = first; i < first + n; i++) begin
      SPI_MOSI = (i < 40) ? f[39 - i] : 1'b0;
      repeat (4) @(negedge clk);
      SPI_Clk = 1'b1;
      last_rise = cyc;
      if (i >= 8 && i < 40) rx = {rx[30:0], SPI_MISO};
      repeat (4) @(negedge clk);
      SPI_Clk = 1'b0;
    end
  endtask

  task automatic spi_frame(input logic [39:0] f, input int nbits, input bit raise_cs);
    @(negedge clk);
    SPI_CS = 1'b0;
    rx = '0;
    repeat (4) @(negedge clk);
    spi_bits(f, 0, nbits);
    repeat (6) @(negedge clk);
    if (raise_cs) begin
      SPI_CS = 1'b1;
      repeat (8) @(negedge clk);
    end
  endtask

  int s0, e0;

  initial begin
    repeat (4) @(negedge clk);
    check("rst_conf0", conf0, 0);
    check("rst_conf1", conf1, 0);
    check("rst_ele1", ele1, 0);
    check("rst_ele2", ele2, 0);
    check("rst_outs", {wr_strobe, wr_addr, frame_err, SPI_MISO}, 0);
    reset_l = 1'b1;
    repeat (6) @(negedge clk);

    // ele1 write; strobe lands on the third clk edge after the 40th SPI_Clk rise pin change
    s0 = strobe_cnt; e0 = err_cnt;
    spi_frame(40'h02_00008000, 40, 1);
    check("ele1_val", ele1, 32'h00008000);
    check("ele1_others", {conf0, conf1, ele2}, 0);
    check("ele1_strobes", strobe_cnt - s0, 1);
    check("ele1_waddr", last_waddr, 2);
    check("ele1_latency", strobe_cyc - last_rise, 3);
    check("ele1_noerr", err_cnt - e0, 0);

    s0 = strobe_cnt;
    spi_frame(40'h00_32CB2190, 40, 1);
    check("conf0_val", conf0, 32'h32CB2190);
    check("conf0_waddr", last_waddr, 0);
    spi_frame(40'h01_00880C32, 40, 1);
    check("conf1_val", conf1, 32'h00880C32);
    check("conf1_waddr", last_waddr, 1);
    check("conf_strobes", strobe_cnt - s0, 2);
`ifdef SPI_READBACK_EN
    spi_frame(40'h00_00000000, 40, 1);
    check("rb_miso", rx, 32'h32CB2190);
    check("rb_conf0", conf0, 0);
    spi_frame(40'h00_32CB2190, 40, 1);
`else
    check("miso_tied", rx, 0);
`endif

    // truncated: address + 3 data bytes
    s0 = strobe_cnt; e0 = err_cnt;
    spi_frame(40'h01_AABBCCDD, 32, 1);
    check("trunc_conf1", conf1, 32'h00880C32);
    check("trunc_err", err_cnt - e0, 1);
    check("trunc_nostrobe", strobe_cnt - s0, 0);

    // unmapped address: error at commit, none at CS rise
    s0 = strobe_cnt; e0 = err_cnt;
    spi_frame(40'h07_DEADBEEF, 40, 0);
    check("bad_err_commit", err_cnt - e0, 1);
    SPI_CS = 1'b1;
    repeat (8) @(negedge clk);
    check("bad_err_total", err_cnt - e0, 1);
    check("bad_nostrobe", strobe_cnt - s0, 0);
    check("bad_regs", {conf0, conf1, ele1, ele2},
          {32'h32CB2190, 32'h00880C32, 32'h00008000, 32'h0});

    // overrun: 41 clocks commits, then errors at CS rise
    s0 = strobe_cnt; e0 = err_cnt;
    spi_frame(40'h03_12345678, 41, 0);
    check("ovr_ele2", ele2, 32'h12345678);
    check("ovr_strobe", strobe_cnt - s0, 1);
    check("ovr_err_pre", err_cnt - e0, 0);
    SPI_CS = 1'b1;
    repeat (8) @(negedge clk);
    check("ovr_err_post", err_cnt - e0, 1);

    // reset after 20 bits; remainder of the frame must be ignored
    @(negedge clk);
    SPI_CS = 1'b0;
    repeat (4) @(negedge clk);
    spi_bits(40'h00_FFFFFFFF, 0, 20);
    reset_l = 1'b0;
    repeat (2) @(negedge clk);
    check("mid_rst_regs", {conf0, conf1, ele1, ele2}, 0);
    check("mid_rst_outs", {wr_strobe, wr_addr, frame_err, SPI_MISO}, 0);
    reset_l = 1'b1;
    s0 = strobe_cnt; e0 = err_cnt;
    spi_bits(40'h00_FFFFFFFF, 20, 20);
    repeat (6) @(negedge clk);
    SPI_CS = 1'b1;
    repeat (8) @(negedge clk);
    check("mid_rst_ignored", {conf0, conf1, ele1, ele2}, 0);
    check("mid_rst_quiet", {strobe_cnt - s0, err_cnt - e0}, 0);
    spi_frame(40'h03_00004000, 40, 1);
    check("post_rst_ele2", ele2, 32'h00004000);
    check("post_rst_others", {conf0, conf1, ele1}, 0);
    check("post_rst_waddr", last_waddr, 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
